// File: rtl/arbiter_n_to_1_request_if.sv
// Request-side handshake bundle: N requestor streams in, one merged stream out.
// master drives requests and output ready; slave is the arbiter.
interface arbiter_n_to_1_request_if #(
   parameter int NUM_MEMORY_REQUESTOR = 2,
   parameter int DEMUX_DATA_WIDTH     = 64
);
   localparam int N  = NUM_MEMORY_REQUESTOR;
   localparam int DW = DEMUX_DATA_WIDTH;

   logic [N-1:0]    request_in_valid;
   logic [N*DW-1:0] request_in_payload;
   logic [N-1:0]    request_in_ready;
   logic [N-1:0]    fifo_request_prog_full;
   logic            request_out_valid;
   logic [DW-1:0]   request_out_payload;
   logic [N-1:0]    request_out_grant;
   logic            request_out_ready;
   logic            fifo_setup_signal;

   modport master (
      output request_in_valid,
      output request_in_payload,
      output request_out_ready,
      input  request_in_ready,
      input  fifo_request_prog_full,
      input  request_out_valid,
      input  request_out_payload,
      input  request_out_grant,
      input  fifo_setup_signal
   );

   modport slave (
      input  request_in_valid,
      input  request_in_payload,
      input  request_out_ready,
      output request_in_ready,
      output fifo_request_prog_full,
      output request_out_valid,
      output request_out_payload,
      output request_out_grant,
      output fifo_setup_signal
   );
endinterface

// File: rtl/arbiter_n_to_1_request.sv
// N-to-1 request merger: per-requestor FIFOs drained round-robin
// into a registered output stage tagged with a one-hot grant.
module arbiter_n_to_1_request #(
   parameter int NUM_MEMORY_REQUESTOR = 2,
   parameter int DEMUX_DATA_WIDTH     = 64,
   parameter int FIFO_WRITE_DEPTH     = 16,
   parameter int PROG_THRESH          = 12,
   parameter int SETUP_CYCLES         = 4
) (
   input logic ap_clk,
   input logic areset_n,
   arbiter_n_to_1_request_if.slave bus
);
   localparam int N     = NUM_MEMORY_REQUESTOR;
   localparam int DW    = DEMUX_DATA_WIDTH;
   localparam int DEPTH = FIFO_WRITE_DEPTH;
   localparam int AW    = $clog2(DEPTH);
   localparam int PW    = (N > 1) ? $clog2(N) : 1;
   localparam int CW    = (SETUP_CYCLES > 0) ? $clog2(SETUP_CYCLES + 1) : 1;

   logic [DW-1:0] mem [N][DEPTH];
   logic [AW-1:0] wptr [N];
   logic [AW-1:0] rptr [N];
   logic [AW:0]   occ  [N];

   logic [N-1:0]  nonempty;
   logic [N-1:0]  in_ready;
   logic [N-1:0]  prog_full;
   logic [N-1:0]  push;
   logic [N-1:0]  pop;

   logic          setup;
   logic [CW-1:0] scnt;

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] idx;
   logic          found;
   logic          load_en;

   logic          out_valid;
   logic [DW-1:0] out_payload;
   logic [N-1:0]  out_grant;

   always_comb begin
      nonempty  = '0;
      in_ready  = '0;
      prog_full = '0;
      for (int i = 0; i < N; i++) begin
         nonempty[i]  = (occ[i] != '0);
         in_ready[i]  = ~setup & (occ[i] != (AW+1)'(DEPTH));
         prog_full[i] = (occ[i] >= (AW+1)'(PROG_THRESH));
      end
   end

   assign push    = bus.request_in_valid & in_ready;
   assign load_en = ~out_valid | bus.request_out_ready;

   // Search upward from the slot after the last winner
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = PW'((int'(rr_ptr) + k) % N);
         if (!found && nonempty[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign pop = (load_en && found) ? (N'(1) << win) : '0;

   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         setup <= 1'b1;
         scnt  <= '0;
      end else if (setup) begin
         if (scnt == CW'(SETUP_CYCLES))
            setup <= 1'b0;
         else
            scnt <= scnt + 1'b1;
      end
   end

   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         for (int i = 0; i < N; i++) begin
            wptr[i] <= '0;
            rptr[i] <= '0;
            occ[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (push[i])
               wptr[i] <= wptr[i] + 1'b1;
            if (pop[i])
               rptr[i] <= rptr[i] + 1'b1;
            if (push[i] && !pop[i])
               occ[i] <= occ[i] + 1'b1;
            else if (!push[i] && pop[i])
               occ[i] <= occ[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      for (int i = 0; i < N; i++)
         if (push[i])
            mem[i][wptr[i]] <= bus.request_in_payload[i*DW +: DW];
   end

   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         out_valid   <= 1'b0;
         out_payload <= '0;
         out_grant   <= '0;
         rr_ptr      <= PW'(N - 1);
      end else if (load_en) begin
         if (found) begin
            out_valid   <= 1'b1;
            out_payload <= mem[win][rptr[win]];
            out_grant   <= N'(1) << win;
            rr_ptr      <= win;
         end else begin
            out_valid   <= 1'b0;
         end
      end
   end

   assign bus.request_in_ready       = in_ready;
   assign bus.fifo_request_prog_full = prog_full;
   assign bus.request_out_valid      = out_valid;
   assign bus.request_out_payload    = out_payload;
   assign bus.request_out_grant      = out_grant;
   assign bus.fifo_setup_signal      = setup;
endmodule

// File: tb/tb_arbiter_n_to_1_request.sv
// Directed bench for arbiter_n_to_1_request with N=4, DW=16,
// depth 16, threshold 12, four setup cycles.
module tb_arbiter_n_to_1_request;
   localparam int N  = 4;
   localparam int DW = 16;

   logic ap_clk;
   logic areset_n;

   int vectors     = 0;
   int miscompares = 0;

   logic [N+DW-1:0] outq [$];
   logic [N-1:0]    acc;
   int              sent [N];
   int              seq;

   arbiter_n_to_1_request_if #(
      .NUM_MEMORY_REQUESTOR(N),
      .DEMUX_DATA_WIDTH(DW)
   ) bus ();

   arbiter_n_to_1_request #(
      .NUM_MEMORY_REQUESTOR(N),
      .DEMUX_DATA_WIDTH(DW),
      .FIFO_WRITE_DEPTH(16),
      .PROG_THRESH(12),
      .SETUP_CYCLES(4)
   ) dut (
      .ap_clk(ap_clk),
      .areset_n(areset_n),
      .bus(bus)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Log the output handshake seen by the coming edge, then step one cycle
   task automatic cyc();
      if (bus.request_out_valid && bus.request_out_ready)
         outq.push_back({bus.request_out_grant, bus.request_out_payload});
      @(posedge ap_clk);
      @(negedge ap_clk);
   endtask

   initial begin
      areset_n               = 1'b0;
      bus.request_in_valid   = '0;
      bus.request_in_payload = '0;
      bus.request_out_ready  = 1'b0;

      // Reset values
      repeat (5) @(negedge ap_clk);
      chk("rst_valid", 32'(bus.request_out_valid), 32'd0);
      chk("rst_payload", 32'(bus.request_out_payload), 32'd0);
      chk("rst_grant", 32'(bus.request_out_grant), 32'd0);
      chk("rst_in_ready", 32'(bus.request_in_ready), 32'd0);
      chk("rst_prog_full", 32'(bus.fifo_request_prog_full), 32'd0);
      chk("rst_setup", 32'(bus.fifo_setup_signal), 32'd1);

      // Setup window
      areset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk("setup_hi", 32'(bus.fifo_setup_signal), 32'd1);
         chk("setup_rdy0", 32'(bus.request_in_ready), 32'd0);
      end
      cyc();
      chk("setup_lo", 32'(bus.fifo_setup_signal), 32'd0);
      chk("setup_rdy1", 32'(bus.request_in_ready), 32'hf);

      // Single beat from requestor 1
      bus.request_in_valid = 4'b0010;
      bus.request_in_payload[1*DW +: DW] = 16'h00a5;
      cyc();
      bus.request_in_valid = '0;
      chk("single_lat0", 32'(bus.request_out_valid), 32'd0);
      cyc();
      chk("single_valid", 32'(bus.request_out_valid), 32'd1);
      chk("single_payload", 32'(bus.request_out_payload), 32'h00a5);
      chk("single_grant", 32'(bus.request_out_grant), 32'b0010);
      cyc();
      chk("single_hold", 32'(bus.request_out_payload), 32'h00a5);

      // Zero-route beat from requestor 3 is still forwarded
      bus.request_in_valid = 4'b1000;
      bus.request_in_payload[3*DW +: DW] = 16'h0000;
      cyc();
      bus.request_in_valid  = '0;
      bus.request_out_ready = 1'b1;
      cyc();
      chk("zero_valid", 32'(bus.request_out_valid), 32'd1);
      chk("zero_payload", 32'(bus.request_out_payload), 32'h0000);
      chk("zero_grant", 32'(bus.request_out_grant), 32'b1000);
      cyc();
      chk("zero_drain", 32'(bus.request_out_valid), 32'd0);
      chk("q_single", 32'(outq.size()), 32'd2);

      // Fairness: four sources, eight beats each
      outq.delete();
      for (int i = 0; i < N; i++) sent[i] = 0;
      for (int c = 0; c < 120 && outq.size() < 32; c++) begin
         for (int i = 0; i < N; i++) begin
            bus.request_in_valid[i] = (sent[i] < 8);
            bus.request_in_payload[i*DW +: DW] = 16'(i*256 + sent[i]);
         end
         acc = bus.request_in_valid & bus.request_in_ready;
         cyc();
         for (int i = 0; i < N; i++)
            if (acc[i]) sent[i]++;
      end
      bus.request_in_valid = '0;
      chk("fair_count", 32'(outq.size()), 32'd32);
      for (int j = 0; j < outq.size(); j++)
         chk($sformatf("fair_beat%0d", j), 32'(outq[j]),
             32'({4'(1 << (j % 4)), 16'((j % 4)*256 + j/4)}));

      // Back-pressure on requestor 0
      outq.delete();
      bus.request_out_ready = 1'b0;
      seq = 0;
      for (int n = 1; n <= 20; n++) begin
         bus.request_in_valid[0] = 1'b1;
         bus.request_in_payload[0 +: DW] = 16'(16'hb000 + seq);
         acc = bus.request_in_valid & bus.request_in_ready;
         cyc();
         if (acc[0]) seq++;
         chk($sformatf("bp_rdy%0d", n), 32'(bus.request_in_ready[0]), 32'(n < 17));
         chk($sformatf("bp_pf%0d", n), 32'(bus.fifo_request_prog_full[0]), 32'(n >= 13));
         if (n >= 2)
            chk($sformatf("bp_hold%0d", n),
                32'({bus.request_out_valid, bus.request_out_payload}),
                32'({1'b1, 16'hb000}));
      end
      chk("bp_accepted", 32'(seq), 32'd17);
      bus.request_in_valid  = '0;
      bus.request_out_ready = 1'b1;
      for (int c = 0; c < 60 && outq.size() < 17; c++) cyc();
      chk("bp_count", 32'(outq.size()), 32'd17);
      for (int j = 0; j < outq.size(); j++)
         chk($sformatf("bp_beat%0d", j), 32'(outq[j]),
             32'({4'b0001, 16'(16'hb000 + j)}));
      cyc();
      chk("bp_idle", 32'(bus.request_out_valid), 32'd0);

      // Wrap: 48 beats through requestor 2 with random valid/ready
      outq.delete();
      seq = 0;
      for (int c = 0; c < 1500 && outq.size() < 48; c++) begin
         bus.request_in_valid[2] = (seq < 48) && ($urandom_range(0, 3) != 0);
         bus.request_in_payload[2*DW +: DW] = 16'(16'hc000 + seq);
         bus.request_out_ready = 1'($urandom_range(0, 1));
         acc = bus.request_in_valid & bus.request_in_ready;
         cyc();
         if (acc[2]) seq++;
      end
      bus.request_in_valid  = '0;
      bus.request_out_ready = 1'b1;
      chk("wrap_count", 32'(outq.size()), 32'd48);
      for (int j = 0; j < outq.size(); j++)
         chk($sformatf("wrap_beat%0d", j), 32'(outq[j]),
             32'({4'b0100, 16'(16'hc000 + j)}));
      cyc();
      chk("wrap_idle", 32'(bus.request_out_valid), 32'd0);

      // Mid-traffic reset with beats buffered
      outq.delete();
      bus.request_out_ready = 1'b0;
      for (int b = 0; b < 6; b++) begin
         bus.request_in_valid[1] = 1'b1;
         bus.request_in_payload[1*DW +: DW] = 16'(16'hd000 + b);
         cyc();
      end
      bus.request_in_valid = '0;
      chk("mid_valid", 32'(bus.request_out_valid), 32'd1);
      #2 areset_n = 1'b0;
      #1;
      chk("mid_async_valid", 32'(bus.request_out_valid), 32'd0);
      chk("mid_async_setup", 32'(bus.fifo_setup_signal), 32'd1);
      chk("mid_async_rdy", 32'(bus.request_in_ready), 32'd0);
      @(negedge ap_clk);
      areset_n = 1'b1;
      bus.request_out_ready = 1'b1;
      for (int c = 0; c < 15; c++) cyc();
      chk("mid_no_stale", 32'(outq.size()), 32'd0);
      chk("mid_idle", 32'(bus.request_out_valid), 32'd0);
      chk("mid_rdy", 32'(bus.request_in_ready), 32'hf);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
